// File: rtl/print_dim_matrix_multi.sv
// print_dim_matrix_multi
// ----------------------
// Prints every stored matrix of one requested dimension (m x n), or one
// selected matrix, over the UART for the matrix-calculator top level.
// Sequence: validate the request against the info table, send the count
// line, then for each matrix send its 1-based index line, read it from
// storage and hand it to the matrix printer.
//
// Ports
//   clk, rst_n             : clock, asynchronous active-low reset
//   start                  : request pulse (sampled only in IDLE)
//   dim_m, dim_n           : requested rows / columns
//   sel_index              : 0 = print all, k = print only matrix k (1-based)
//   busy / done / error    : status; done and error are 1-cycle pulses
//   info_table             : per-dimension stored-matrix counts
//   read_en, dimM, dimN,
//   mat_index, rd_ready,
//   rd_data_flow           : storage read port (mat_index is 0-based)
//   matrix_printer_start,
//   matrix_printer_done,
//   matrix_flat, use_crlf  : matrix printer handshake and latched matrix
//   uart_tx_busy,
//   uart_tx_en, uart_tx_data : byte-wide UART transmitter handshake
module print_dim_matrix_multi #(
  parameter int MAX_DIM    = 5,
  parameter int SLOTS      = 2,
  parameter int CNT_W      = 2,
  parameter int ELEM_W     = 8,
  parameter int RD_TIMEOUT = 1023
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [2:0]                        dim_m,
  input  logic [2:0]                        dim_n,
  input  logic [3:0]                        sel_index,
  output logic                              busy,
  output logic                              done,
  output logic                              error,
  input  logic [MAX_DIM*MAX_DIM*CNT_W-1:0]  info_table,
  output logic                              read_en,
  output logic [2:0]                        dimM,
  output logic [2:0]                        dimN,
  output logic [3:0]                        mat_index,
  input  logic                              rd_ready,
  input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] rd_data_flow,
  output logic                              matrix_printer_start,
  input  logic                              matrix_printer_done,
  output logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] matrix_flat,
  output logic                              use_crlf,
  input  logic                              uart_tx_busy,
  output logic                              uart_tx_en,
  output logic [7:0]                        uart_tx_data
);

  localparam int TBL_W  = MAX_DIM*MAX_DIM*CNT_W;
  localparam int FLAT_W = MAX_DIM*MAX_DIM*ELEM_W;
  localparam int TO_W   = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_TX_CNT, S_TX_IDX, S_READ_REQ, S_READ_WAIT,
    S_PRINT_START, S_PRINT_WAIT, S_DONE, S_ERROR
  } state_t;

  // Count for (m,n); index math done in int so no aliasing for small MAX_DIM.
  function automatic logic [7:0] lookup_cnt(input logic [TBL_W-1:0] tbl,
                                            input logic [2:0] m,
                                            input logic [2:0] n);
    int idx;
    idx = ((int'(m) - 1) * MAX_DIM + (int'(n) - 1)) * CNT_W;
    lookup_cnt = 8'(tbl[idx +: CNT_W]);
  endfunction

  state_t            state_r, state_s;
  logic [7:0]        cnt_r, cnt_s;
  logic [3:0]        rem_r, rem_s;
  logic [2:0]        dim_m_r, dim_m_s, dim_n_r, dim_n_s;
  logic [2:0]        ptr_r, ptr_s;
  logic              in_prog_r, in_prog_s;
  logic              tx_busy_q_r;
  logic [TO_W-1:0]   to_cnt_r, to_cnt_s;

  logic              busy_s, done_s, error_s, read_en_s, mps_s, tx_en_s;
  logic [2:0]        dimM_s, dimN_s;
  logic [3:0]        mat_index_s;
  logic [FLAT_W-1:0] matrix_flat_s;
  logic [7:0]        tx_data_s;

  logic [3:0][7:0]   line_s;
  logic [2:0]        len_s;
  logic [7:0]        tens_s, ones_s, cur_byte_s, look_s;
  logic              dims_ok_s, fall_s;
  logic [TO_W-1:0]   to_inc_s;
  logic [3:0]        rem_dec_s;

  assign use_crlf = 1'b1;

  // Build the line (bytes + length) that the current TX state is sending.
  always_comb begin
    tens_s = cnt_r / 8'd10;
    ones_s = cnt_r % 8'd10;
    line_s = '0;
    len_s  = 3'd0;
    case (state_r)
      S_TX_CNT: begin
        // Decimal count without leading zero, then CR LF.
        if (tens_s != 8'd0) begin
          line_s[0] = 8'h30 + tens_s;
          line_s[1] = 8'h30 + ones_s;
          line_s[2] = 8'h0D;
          line_s[3] = 8'h0A;
          len_s     = 3'd4;
        end else begin
          line_s[0] = 8'h30 + ones_s;
          line_s[1] = 8'h0D;
          line_s[2] = 8'h0A;
          len_s     = 3'd3;
        end
      end
      S_TX_IDX: begin
        line_s[0] = 8'h30 + {4'd0, mat_index} + 8'd1;
        line_s[1] = 8'h0D;
        line_s[2] = 8'h0A;
        len_s     = 3'd3;
      end
      default: begin
        len_s = 3'd0;
      end
    endcase
    cur_byte_s = line_s[ptr_r[1:0]];
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    rem_s         = rem_r;
    dim_m_s       = dim_m_r;
    dim_n_s       = dim_n_r;
    ptr_s         = ptr_r;
    in_prog_s     = in_prog_r;
    to_cnt_s      = to_cnt_r;
    done_s        = 1'b0;
    error_s       = 1'b0;
    read_en_s     = 1'b0;
    mps_s         = 1'b0;
    tx_en_s       = 1'b0;
    dimM_s        = dimM;
    dimN_s        = dimN;
    mat_index_s   = mat_index;
    matrix_flat_s = matrix_flat;
    tx_data_s     = uart_tx_data;
    fall_s        = tx_busy_q_r & ~uart_tx_busy;
    to_inc_s      = to_cnt_r + TO_W'(1);
    rem_dec_s     = rem_r - 4'd1;
    dims_ok_s     = (dim_m != 3'd0) && (int'(dim_m) <= MAX_DIM) &&
                    (dim_n != 3'd0) && (int'(dim_n) <= MAX_DIM);
    // The table is only indexed for legal dimensions.
    if (dims_ok_s) begin
      look_s = lookup_cnt(info_table, dim_m, dim_n);
    end else begin
      look_s = 8'd0;
    end

    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_CHECK;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_CHECK: begin
        ptr_s     = 3'd0;
        in_prog_s = 1'b0;
        if (!dims_ok_s || (look_s == 8'd0) || (int'(look_s) > SLOTS) ||
            ({4'd0, sel_index} > look_s)) begin
          state_s = S_ERROR;
        end else begin
          cnt_s   = look_s;
          dim_m_s = dim_m;
          dim_n_s = dim_n;
          if (sel_index != 4'd0) begin
            mat_index_s = sel_index - 4'd1;
            rem_s       = 4'd1;
          end else begin
            mat_index_s = 4'd0;
            rem_s       = look_s[3:0];
          end
          state_s = S_TX_CNT;
        end
      end
      S_TX_CNT, S_TX_IDX: begin
        // One byte in flight at a time; completion is the falling edge of
        // uart_tx_busy seen while that byte is outstanding.
        if (in_prog_r) begin
          if (fall_s) begin
            in_prog_s = 1'b0;
            ptr_s     = ptr_r + 3'd1;
          end else begin
            in_prog_s = 1'b1;
          end
        end else if (ptr_r < len_s) begin
          if (!uart_tx_busy) begin
            tx_en_s   = 1'b1;
            tx_data_s = cur_byte_s;
            in_prog_s = 1'b1;
          end else begin
            in_prog_s = 1'b0;
          end
        end else if (!uart_tx_busy) begin
          ptr_s = 3'd0;
          if (state_r == S_TX_CNT) begin
            state_s = S_TX_IDX;
          end else begin
            state_s   = S_READ_REQ;
            read_en_s = 1'b1;
            dimM_s    = dim_m_r;
            dimN_s    = dim_n_r;
          end
        end else begin
          state_s = state_r;
        end
      end
      S_READ_REQ: begin
        to_cnt_s = '0;
        state_s  = S_READ_WAIT;
      end
      S_READ_WAIT: begin
        if (rd_ready) begin
          matrix_flat_s = rd_data_flow;
          mps_s         = 1'b1;
          state_s       = S_PRINT_START;
        end else if (to_inc_s == TO_W'(RD_TIMEOUT)) begin
          state_s = S_ERROR;
        end else begin
          to_cnt_s = to_inc_s;
        end
      end
      S_PRINT_START: begin
        state_s = S_PRINT_WAIT;
      end
      S_PRINT_WAIT: begin
        if (matrix_printer_done) begin
          rem_s = rem_dec_s;
          if (rem_dec_s != 4'd0) begin
            mat_index_s = mat_index + 4'd1;
            ptr_s       = 3'd0;
            state_s     = S_TX_IDX;
          end else begin
            state_s = S_DONE;
          end
        end else begin
          state_s = S_PRINT_WAIT;
        end
      end
      S_DONE: begin
        done_s  = 1'b1;
        state_s = S_IDLE;
      end
      S_ERROR: begin
        error_s = 1'b1;
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
    busy_s = (state_s != S_IDLE);
  end

  // State, context and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r              <= S_IDLE;
      cnt_r                <= 8'd0;
      rem_r                <= 4'd0;
      dim_m_r              <= 3'd0;
      dim_n_r              <= 3'd0;
      ptr_r                <= 3'd0;
      in_prog_r            <= 1'b0;
      tx_busy_q_r          <= 1'b0;
      to_cnt_r             <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      error                <= 1'b0;
      read_en              <= 1'b0;
      dimM                 <= 3'd0;
      dimN                 <= 3'd0;
      mat_index            <= 4'd0;
      matrix_printer_start <= 1'b0;
      matrix_flat          <= '0;
      uart_tx_en           <= 1'b0;
      uart_tx_data         <= 8'd0;
    end else begin
      state_r              <= state_s;
      cnt_r                <= cnt_s;
      rem_r                <= rem_s;
      dim_m_r              <= dim_m_s;
      dim_n_r              <= dim_n_s;
      ptr_r                <= ptr_s;
      in_prog_r            <= in_prog_s;
      tx_busy_q_r          <= uart_tx_busy;
      to_cnt_r             <= to_cnt_s;
      busy                 <= busy_s;
      done                 <= done_s;
      error                <= error_s;
      read_en              <= read_en_s;
      dimM                 <= dimM_s;
      dimN                 <= dimN_s;
      mat_index            <= mat_index_s;
      matrix_printer_start <= mps_s;
      matrix_flat          <= matrix_flat_s;
      uart_tx_en           <= tx_en_s;
      uart_tx_data         <= tx_data_s;
    end
  end

endmodule

// File: tb/tb_print_dim_matrix_multi.sv
// tb_print_dim_matrix_multi
// Self-checking bench: UART, storage and printer models respond with random
// latencies; each request is compared against a string-level model of the
// expected UART text, read sequence and outcome.
module tb_print_dim_matrix_multi;
  localparam int MAX_DIM    = 5;
  localparam int SLOTS      = 9;
  localparam int CNT_W      = 4;
  localparam int ELEM_W     = 8;
  localparam int RD_TIMEOUT = 15;
  localparam int TBL_W      = MAX_DIM*MAX_DIM*CNT_W;
  localparam int FLAT_W     = MAX_DIM*MAX_DIM*ELEM_W;

  typedef logic [7:0] bq_t[$];
  typedef int         iq_t[$];

  logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [2:0]        dim_m = 3'd0, dim_n = 3'd0;
  logic [3:0]        sel_index = 4'd0;
  logic              busy, done, error;
  logic [TBL_W-1:0]  info_table = '0;
  logic              read_en;
  logic [2:0]        dimM, dimN;
  logic [3:0]        mat_index;
  logic              rd_ready = 1'b0;
  logic [FLAT_W-1:0] rd_data_flow = '0;
  logic              matrix_printer_start, matrix_printer_done = 1'b0;
  logic [FLAT_W-1:0] matrix_flat;
  logic              use_crlf;
  logic              uart_tx_busy = 1'b0;
  logic              uart_tx_en;
  logic [7:0]        uart_tx_data;

  print_dim_matrix_multi #(.MAX_DIM(MAX_DIM), .SLOTS(SLOTS), .CNT_W(CNT_W),
                           .ELEM_W(ELEM_W), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dim_m(dim_m), .dim_n(dim_n),
    .sel_index(sel_index), .busy(busy), .done(done), .error(error),
    .info_table(info_table), .read_en(read_en), .dimM(dimM), .dimN(dimN),
    .mat_index(mat_index), .rd_ready(rd_ready), .rd_data_flow(rd_data_flow),
    .matrix_printer_start(matrix_printer_start),
    .matrix_printer_done(matrix_printer_done), .matrix_flat(matrix_flat),
    .use_crlf(use_crlf), .uart_tx_busy(uart_tx_busy), .uart_tx_en(uart_tx_en),
    .uart_tx_data(uart_tx_data));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  task automatic check_val(input string tag, input logic [255:0] got,
                           input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Model state (owned by the negedge model process)
  bit                storage_dead = 1'b0;
  logic [7:0]        tx_q[$];
  int                rd_idx_q[$];
  logic [5:0]        rd_dim_q[$];
  logic [FLAT_W-1:0] rd_data_q[$];
  logic [FLAT_W-1:0] pr_data_q[$];
  int                pr_bytes_q[$];
  int                busy_left = 0, rd_pend = 0, pr_pend = 0;
  int                done_cnt = 0, err_cnt = 0, end_cyc = 0, rd_cyc = 0;
  logic              busy_at_end = 1'b0;

  function automatic logic [FLAT_W-1:0] rand_mat();
    logic [FLAT_W-1:0] v;
    v = '0;
    for (int i = 0; i < (FLAT_W + 31) / 32; i++)
      v = (v << 32) | FLAT_W'($urandom);
    return v;
  endfunction

  // UART, storage and printer models plus pulse monitor, all at negedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      uart_tx_busy = 1'b0; busy_left = 0; rd_pend = 0; pr_pend = 0;
      rd_ready = 1'b0; matrix_printer_done = 1'b0;
    end else begin
      if (uart_tx_en) begin
        tx_q.push_back(uart_tx_data);
        uart_tx_busy = 1'b1;
        busy_left = $urandom_range(1, 4);
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) uart_tx_busy = 1'b0;
      end
      rd_ready = 1'b0;
      if (rd_pend > 0) begin
        rd_pend--;
        if (rd_pend == 0) rd_ready = 1'b1;
      end
      if (read_en) begin
        rd_idx_q.push_back(int'(mat_index));
        rd_dim_q.push_back({dimM, dimN});
        rd_cyc = cyc;
        rd_data_flow = rand_mat();
        rd_data_q.push_back(rd_data_flow);
        if (!storage_dead) rd_pend = $urandom_range(1, 5);
      end
      matrix_printer_done = 1'b0;
      if (pr_pend > 0) begin
        pr_pend--;
        if (pr_pend == 0) matrix_printer_done = 1'b1;
      end
      if (matrix_printer_start) begin
        pr_data_q.push_back(matrix_flat);
        pr_bytes_q.push_back(tx_q.size());
        pr_pend = $urandom_range(1, 6);
      end
      if (done)  begin done_cnt++; end_cyc = cyc; busy_at_end = busy; end
      if (error) begin err_cnt++;  end_cyc = cyc; busy_at_end = busy; end
    end
  end

  // Reference: expected outcome, UART text and read indices of one request.
  task automatic ref_model(input int m, n, sel, cnt, input bit dead,
                           output bit err, output bq_t bytes, output iq_t idx,
                           output int hdr_len);
    int first, last;
    bytes = {}; idx = {}; err = 1'b0; hdr_len = 0;
    if (m < 1 || m > MAX_DIM || n < 1 || n > MAX_DIM || cnt == 0 ||
        cnt > SLOTS || sel > cnt) begin
      err = 1'b1;
      return;
    end
    if (cnt >= 10) bytes.push_back(8'(48 + cnt / 10));
    bytes.push_back(8'(48 + cnt % 10));
    bytes.push_back(8'd13); bytes.push_back(8'd10);
    hdr_len = bytes.size();
    first = (sel != 0) ? sel - 1 : 0;
    last  = (sel != 0) ? sel - 1 : cnt - 1;
    for (int k = first; k <= last; k++) begin
      bytes.push_back(8'(48 + k + 1));
      bytes.push_back(8'd13); bytes.push_back(8'd10);
      idx.push_back(k);
      if (dead) begin err = 1'b1; return; end
    end
  endtask

  task automatic load_table(input int m, n, cnt);
    for (int i = 0; i < MAX_DIM*MAX_DIM; i++)
      info_table[i*CNT_W +: CNT_W] = 4'($urandom_range(0, 15));
    if (m >= 1 && m <= MAX_DIM && n >= 1 && n <= MAX_DIM)
      info_table[((m-1)*MAX_DIM + (n-1))*CNT_W +: CNT_W] = 4'(cnt);
  endtask

  task automatic run_case(input int m, n, sel, cnt, input bit dead);
    bit  exp_err, fin;
    bq_t exp_bytes;
    iq_t exp_idx;
    int  hdr, tx_b, rd_b, pr_b, dn_b, er_b, st_cyc, nb, nr, np;
    storage_dead = dead;
    load_table(m, n, cnt);
    ref_model(m, n, sel, cnt, dead, exp_err, exp_bytes, exp_idx, hdr);
    tx_b = tx_q.size(); rd_b = rd_idx_q.size(); pr_b = pr_data_q.size();
    dn_b = done_cnt; er_b = err_cnt;
    @(negedge clk);
    dim_m = 3'(m); dim_n = 3'(n); sel_index = 4'(sel); start = 1'b1;
    st_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    // Inputs changed after CHECK must not matter.
    dim_m = 3'($urandom); dim_n = 3'($urandom); sel_index = 4'($urandom);
    load_table(0, 0, 0);
    fin = 1'b0;
    for (int i = 0; i < 5000 && !fin; i++) begin
      @(negedge clk);
      if (done_cnt + err_cnt > dn_b + er_b) fin = 1'b1;
    end
    repeat (8) @(negedge clk);
    check_val("finished", fin, 1'b1);
    check_val("done_pulses", done_cnt - dn_b, exp_err ? 0 : 1);
    check_val("error_pulses", err_cnt - er_b, exp_err ? 1 : 0);
    check_val("busy_at_end", busy_at_end, 1'b0);
    nb = tx_q.size() - tx_b;
    check_val("byte_count", nb, exp_bytes.size());
    for (int i = 0; i < nb && i < exp_bytes.size(); i++)
      check_val($sformatf("byte%0d", i), tx_q[tx_b + i], exp_bytes[i]);
    nr = rd_idx_q.size() - rd_b;
    check_val("read_count", nr, exp_idx.size());
    for (int i = 0; i < nr && i < exp_idx.size(); i++) begin
      check_val($sformatf("read_idx%0d", i), rd_idx_q[rd_b + i], exp_idx[i]);
      check_val("read_dims", rd_dim_q[rd_b + i], {3'(m), 3'(n)});
    end
    np = pr_data_q.size() - pr_b;
    check_val("print_count", np, exp_err ? 0 : exp_idx.size());
    for (int j = 0; j < np && j < nr; j++) begin
      check_val("print_data", pr_data_q[pr_b + j], rd_data_q[rd_b + j]);
      check_val("print_order", pr_bytes_q[pr_b + j] - tx_b, hdr + 3*(j+1));
    end
    if (exp_err && !dead)
      check_val("err_latency_ok", (end_cyc - st_cyc) <= 3, 1'b1);
    if (dead)
      check_val("timeout_latency_ok", (end_cyc - rd_cyc) <= RD_TIMEOUT + 2, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_busy"}, busy, 1'b0);
    check_val({tag, "_done"}, done, 1'b0);
    check_val({tag, "_error"}, error, 1'b0);
    check_val({tag, "_read_en"}, read_en, 1'b0);
    check_val({tag, "_mps"}, matrix_printer_start, 1'b0);
    check_val({tag, "_tx_en"}, uart_tx_en, 1'b0);
    check_val({tag, "_tx_data"}, uart_tx_data, 8'd0);
    check_val({tag, "_dims"}, {dimM, dimN, mat_index}, 10'd0);
    check_val({tag, "_flat"}, matrix_flat, '0);
    check_val({tag, "_crlf"}, use_crlf, 1'b1);
  endtask

  task automatic reset_mid_tx();
    int tx_b, dn_b, er_b;
    bit seen;
    storage_dead = 1'b0;
    load_table(2, 3, 3);
    tx_b = tx_q.size();
    @(negedge clk);
    dim_m = 3'd2; dim_n = 3'd3; sel_index = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (tx_q.size() > tx_b) seen = 1'b1;
    end
    check_val("rst_reached_tx", seen, 1'b1);
    dn_b = done_cnt; er_b = err_cnt;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (4) @(negedge clk);
    check_val("midrst_held_done", done | error | busy, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_val("midrst_no_pulse", (done_cnt - dn_b) + (err_cnt - er_b), 0);
    run_case(2, 3, 0, 3, 1'b0);
  endtask

  initial begin
    int m, n, c, s;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_case(2, 3, 0, 2, 1'b0);   // print all, cnt 2
    run_case(2, 3, 2, 2, 1'b0);   // select matrix 2
    run_case(0, 3, 0, 2, 1'b0);   // dim_m = 0
    run_case(6, 3, 0, 2, 1'b0);   // dim_m > MAX_DIM
    run_case(2, 3, 0, 0, 1'b0);   // cnt = 0
    run_case(2, 3, 3, 2, 1'b0);   // sel beyond cnt
    run_case(4, 4, 0, 9, 1'b0);   // cnt = SLOTS = 9
    run_case(1, 1, 0, 12, 1'b0);  // cnt > SLOTS
    run_case(5, 5, 1, 1, 1'b0);   // largest legal dimension
    run_case(3, 5, 0, 2, 1'b1);   // storage timeout
    for (int t = 0; t < 20; t++) begin
      m = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : $urandom_range(1, MAX_DIM);
      n = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : $urandom_range(1, MAX_DIM);
      c = $urandom_range(0, 11);
      s = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, c + 1);
      run_case(m, n, s, c, 1'b0);
    end
    reset_mid_tx();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
